// File: rtl/adc_emulator_if.sv
// adc_emulator_if: conversion/readout bundle between the trigger/reader logic and the ADC.
//   master : trigger/reader side, drives cnv, sck, mode, pattern, overrun_clr
//   slave  : ADC (emulator) side, drives busy, sdo, overrun, conv_count
interface adc_emulator_if #(
   parameter int unsigned DATA_WIDTH = 24
);
   logic                  cnv;
   logic                  busy;
   logic                  sck;
   logic                  sdo;
   logic [1:0]            mode;
   logic [DATA_WIDTH-1:0] pattern;
   logic                  overrun;
   logic                  overrun_clr;
   logic [15:0]           conv_count;

   modport master (
      output cnv, sck, mode, pattern, overrun_clr,
      input  busy, sdo, overrun, conv_count
   );

   modport slave (
      input  cnv, sck, mode, pattern, overrun_clr,
      output busy, sdo, overrun, conv_count
   );
endinterface

// File: rtl/adc_emulator.sv
// adc_emulator: stands in for the physical ADC. A cnv rise starts a busy phase of CNV_CYCLES
// clocks; the selected sample (ramp, constant pattern or LFSR) is then shifted out MSB-first on
// sdo, one bit per reader sck rise.
//   i_clk   : clock
//   i_reset : synchronous active-high reset
//   adc     : adc_emulator_if slave (cnv/sck/mode/pattern/overrun_clr in,
//             busy/sdo/overrun/conv_count out)
module adc_emulator #(
   parameter int unsigned CNV_CYCLES = 28,
   parameter int unsigned DATA_WIDTH = 24,
   parameter int unsigned RAMP_STEP  = 1
) (
   input logic           i_clk,
   input logic           i_reset,
   adc_emulator_if.slave adc
);
   localparam int unsigned CntW = (CNV_CYCLES > 1) ? $clog2(CNV_CYCLES) : 1;
   localparam int unsigned BitW = $clog2(DATA_WIDTH + 1);

   typedef enum logic [1:0] {StIdle, StConvert, StShift} state_e;

   state_e                r_state;
   logic                  r_cnv_q;
   logic                  r_sck_q;
   logic                  r_busy;
   logic                  r_sdo;
   logic                  r_overrun;
   logic [CntW-1:0]       r_cnt;
   logic [BitW-1:0]       r_bits;
   logic [DATA_WIDTH-1:0] r_shreg;
   logic [DATA_WIDTH-1:0] r_ramp;
   logic [31:0]           r_lfsr;
   logic [15:0]           r_conv_count;

   logic                  w_cnv_rise;
   logic                  w_sck_rise;
   logic [DATA_WIDTH-1:0] w_sample;
   logic [DATA_WIDTH-1:0] w_shreg_shifted;
   logic [31:0]           w_lfsr_next;

   assign w_cnv_rise      = adc.cnv & ~r_cnv_q;
   assign w_sck_rise      = adc.sck & ~r_sck_q;
   assign w_shreg_shifted = r_shreg << 1;
   // Fibonacci taps for x^32 + x^22 + x^2 + x + 1
   assign w_lfsr_next     = {r_lfsr[30:0], r_lfsr[31] ^ r_lfsr[21] ^ r_lfsr[1] ^ r_lfsr[0]};

   always_comb begin
      w_sample = adc.pattern;
      case (adc.mode)
         2'd0:    w_sample = r_ramp;
         2'd2:    w_sample = r_lfsr[DATA_WIDTH-1:0];
         default: w_sample = adc.pattern;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state      <= StIdle;
         r_cnv_q      <= 1'b0;
         r_sck_q      <= 1'b0;
         r_busy       <= 1'b0;
         r_sdo        <= 1'b0;
         r_overrun    <= 1'b0;
         r_cnt        <= '0;
         r_bits       <= '0;
         r_shreg      <= '0;
         r_ramp       <= '0;
         r_lfsr       <= 32'd1;
         r_conv_count <= '0;
      end else begin
         r_cnv_q <= adc.cnv;
         r_sck_q <= adc.sck;

         // A new rise during a conversion is the only overrun source; set beats clear
         if ((r_state == StConvert) && w_cnv_rise) begin
            r_overrun <= 1'b1;
         end else if (adc.overrun_clr) begin
            r_overrun <= 1'b0;
         end

         case (r_state)
            StIdle, StShift: begin
               if (w_cnv_rise) begin
                  // Any unread bits of a readout in progress are dropped
                  r_state <= StConvert;
                  r_cnt   <= CntW'(CNV_CYCLES - 1);
                  r_busy  <= 1'b1;
                  r_sdo   <= 1'b0;
                  r_bits  <= '0;
               end else if ((r_state == StShift) && w_sck_rise) begin
                  r_shreg <= w_shreg_shifted;
                  r_bits  <= r_bits - BitW'(1);
                  if (r_bits == BitW'(1)) begin
                     r_state <= StIdle;
                     r_sdo   <= 1'b0;
                  end else begin
                     r_sdo <= w_shreg_shifted[DATA_WIDTH-1];
                  end
               end
            end
            StConvert: begin
               if (r_cnt == '0) begin
                  r_state      <= StShift;
                  r_busy       <= 1'b0;
                  r_shreg      <= w_sample;
                  r_sdo        <= w_sample[DATA_WIDTH-1];
                  r_bits       <= BitW'(DATA_WIDTH);
                  r_conv_count <= r_conv_count + 16'd1;
                  r_ramp       <= r_ramp + DATA_WIDTH'(RAMP_STEP);
                  r_lfsr       <= w_lfsr_next;
               end else begin
                  r_cnt <= r_cnt - CntW'(1);
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign adc.busy       = r_busy;
   assign adc.sdo        = r_sdo;
   assign adc.overrun    = r_overrun;
   assign adc.conv_count = r_conv_count;
endmodule

// File: tb/tb_adc_emulator.sv
// tb_adc_emulator: directed scenarios plus randomized traffic for adc_emulator. A behavioural
// model (busy countdown + queue of pending sample bits) predicts busy/sdo/overrun/conv_count
// every cycle; directed scenarios also compare read-back words against hand-computed values.
module tb_adc_emulator;
   localparam int unsigned DW  = 24;
   localparam int unsigned CNV = 28;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   adc_emulator_if #(.DATA_WIDTH(DW)) adc_if ();

   adc_emulator #(
      .CNV_CYCLES(CNV),
      .DATA_WIDTH(DW),
      .RAMP_STEP (1)
   ) u_dut (
      .i_clk  (clk),
      .i_reset(rst),
      .adc    (adc_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         if (errors <= 40) $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, got, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit          m_valid;
   bit          m_cnv_prev, m_sck_prev, m_ovr;
   int          m_busy_left;
   bit          m_bits[$];
   int unsigned m_count, m_ramp;
   logic [31:0] m_lfsr;

   function automatic logic [31:0] lfsr_step(input logic [31:0] l);
      return {l[30:0], l[31] ^ l[21] ^ l[1] ^ l[0]};
   endfunction

   always @(posedge clk) begin
      bit          cr, sr;
      logic [31:0] s;
      if (rst) begin
         m_valid = 1; m_cnv_prev = 0; m_sck_prev = 0; m_ovr = 0; m_busy_left = 0;
         m_bits.delete(); m_count = 0; m_ramp = 0; m_lfsr = 32'd1;
      end else if (m_valid) begin
         cr = adc_if.cnv && !m_cnv_prev;
         sr = adc_if.sck && !m_sck_prev;
         m_cnv_prev = adc_if.cnv;
         m_sck_prev = adc_if.sck;
         if (m_busy_left > 0) begin
            if (cr) m_ovr = 1;
            else if (adc_if.overrun_clr) m_ovr = 0;
            m_busy_left--;
            if (m_busy_left == 0) begin
               if (adc_if.mode == 2'd0) s = m_ramp;
               else if (adc_if.mode == 2'd2) s = m_lfsr;
               else s = 32'(adc_if.pattern);
               for (int i = DW - 1; i >= 0; i--) m_bits.push_back(s[i]);
               m_count = (m_count + 1) % 65536;
               m_ramp  = (m_ramp + 1) % (1 << DW);
               m_lfsr  = lfsr_step(m_lfsr);
            end
         end else begin
            if (adc_if.overrun_clr) m_ovr = 0;
            if (cr) begin
               m_bits.delete();
               m_busy_left = CNV;
            end else if (sr && m_bits.size() > 0) begin
               void'(m_bits.pop_front());
            end
         end
      end
   end

   // Compare process: outputs are registered, so the falling edge is a safe sample point
   always @(negedge clk) begin
      if (m_valid) begin
         chk("busy", 32'(adc_if.busy), 32'(m_busy_left > 0));
         chk("sdo", 32'(adc_if.sdo), (m_bits.size() > 0) ? 32'(m_bits[0]) : 32'd0);
         chk("overrun", 32'(adc_if.overrun), 32'(m_ovr));
         chk("conv_count", 32'(adc_if.conv_count), m_count);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
   endtask

   task automatic pulse_cnv();
      adc_if.cnv = 1'b1;
      tick();
      adc_if.cnv = 1'b0;
   endtask

   // Counts busy cycles (bounded); optionally re-pulses cnv at busy cycle rep_at
   task automatic measure_busy(input int rep_at, output int n);
      n = 0;
      while (adc_if.busy && n < 200) begin
         n++;
         adc_if.cnv = (n == rep_at);
         tick();
      end
      adc_if.cnv = 1'b0;
   endtask

   task automatic read_bits(input int nb, output logic [31:0] w);
      w = '0;
      for (int i = 0; i < nb; i++) begin
         w = {w[30:0], adc_if.sdo};
         adc_if.sck = 1'b1;
         tick();
         adc_if.sck = 1'b0;
         tick();
      end
   endtask

   task automatic convert_and_read(input string name, input logic [31:0] exp);
      int          n;
      logic [31:0] w;
      pulse_cnv();
      measure_busy(0, n);
      chk({name, "_busy_len"}, n, CNV);
      read_bits(DW, w);
      chk(name, w, exp);
   endtask

   initial begin
      int          n;
      logic [31:0] w;
      checks = 0;
      errors = 0;
      adc_if.cnv = 0; adc_if.sck = 0; adc_if.mode = 2'd0;
      adc_if.pattern = '0; adc_if.overrun_clr = 0;
      rst = 1'b1;
      tick(3);
      rst = 1'b0;
      tick();
      chk("reset_busy", 32'(adc_if.busy), 0);
      chk("reset_count", 32'(adc_if.conv_count), 0);

      // Ramp: first two conversions read 0 and 1
      convert_and_read("ramp0", 32'h000000);
      convert_and_read("ramp1", 32'h000001);
      chk("count_after_two", 32'(adc_if.conv_count), 2);

      // Constant pattern, then an extra sck after the word is exhausted
      adc_if.mode = 2'd1;
      adc_if.pattern = 24'hA5C3F0;
      convert_and_read("pattern", 32'h00A5C3F0);
      read_bits(1, w);
      chk("pattern_extra_bit", w, 0);
      chk("idle_sdo", 32'(adc_if.sdo), 0);

      // Re-trigger during conversion: timing unaffected, overrun sticky until cleared
      pulse_cnv();
      measure_busy(10, n);
      chk("overrun_busy_len", n, CNV);
      chk("overrun_set", 32'(adc_if.overrun), 1);
      tick(3);
      chk("overrun_sticky", 32'(adc_if.overrun), 1);
      adc_if.overrun_clr = 1'b1;
      tick();
      adc_if.overrun_clr = 1'b0;
      chk("overrun_cleared", 32'(adc_if.overrun), 0);

      // LFSR from seed 1: 1, 3, 6
      do_reset();
      adc_if.mode = 2'd2;
      convert_and_read("lfsr0", 32'h000001);
      convert_and_read("lfsr1", 32'h000003);
      convert_and_read("lfsr2", 32'h000006);

      // Abandoned readout: new conversion after 8 bits, full fresh sample, no overrun
      do_reset();
      adc_if.mode = 2'd0;
      convert_and_read("abort_first", 32'h000000);
      pulse_cnv();
      measure_busy(0, n);
      read_bits(8, w);
      pulse_cnv();
      chk("abort_sdo_busy", 32'(adc_if.sdo), 0);
      measure_busy(0, n);
      chk("abort_busy_len", n, CNV);
      read_bits(DW, w);
      chk("abort_sample", w, 32'h000002);
      chk("abort_no_overrun", 32'(adc_if.overrun), 0);

      // Reset mid-conversion
      pulse_cnv();
      tick(14);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midreset_busy", 32'(adc_if.busy), 0);
      chk("midreset_count", 32'(adc_if.conv_count), 0);
      convert_and_read("midreset_ramp", 32'h000000);

      // Randomized traffic, checked every cycle by the compare process
      for (int i = 0; i < 6000; i++) begin
         adc_if.cnv = ($urandom_range(0, 24) == 0);
         adc_if.sck = $urandom_range(0, 1);
         adc_if.overrun_clr = ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 99) == 0) adc_if.mode = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 99) == 0) adc_if.pattern = DW'($urandom);
         rst = ($urandom_range(0, 499) == 0);
         tick();
      end
      adc_if.cnv = 0; adc_if.sck = 0; adc_if.overrun_clr = 0; rst = 0;
      tick(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/adc_emulator.md
# adc_emulator

Synthesizable responder for the ADC conversion/readout interface: it answers `cnv` pulses from the trigger logic with a `busy` phase of programmable length, then serves the converted sample MSB-first on `sdo` under reader-driven `sck`. It sits in place of the physical ADC in loopback builds and FPGA self-test, so the trigger and readout path can be exercised with deterministic data. All inputs originate in the `clk` domain; no synchronizers are required.

## Interface
- `CNV_CYCLES`, 28: `busy` high time in `clk` cycles (≥2).
- `DATA_WIDTH`, 24: sample width in bits (1..32).
- `RAMP_STEP`, 1: ramp increment per completed conversion.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `cnv` in 1: conversion start; rising edge is significant.
- `busy` out 1: conversion in progress.
- `sck` in 1: readout clock from reader; rising edge is significant.
- `sdo` out 1: serial sample data, MSB first.
- `mode` in 2: 0 ramp, 1 constant `pattern`, 2 LFSR, 3 same as 1.
- `pattern` in DATA_WIDTH: constant sample for modes 1/3.
- `overrun` out 1: sticky; `cnv` rise seen while busy.
- `overrun_clr` in 1: clears `overrun` (set wins on the same cycle).
- `conv_count` out 16: completed conversions, wraps at 2^16.

## Operation
- Edge detect: `cnv_q` and `sck_q` register the previous input values; rise = in & ~q, evaluated combinationally.
- States: IDLE (no data), CONVERT, SHIFT (bits remaining > 0). SHIFT returns to IDLE once all bits have shifted.
- IDLE/SHIFT + `cnv` rise: enter CONVERT, load down-counter with CNV_CYCLES-1, set `busy`. A readout in progress is abandoned and its remaining bits discarded; this does not set `overrun`.
- CONVERT + `cnv` rise: ignored for timing; `overrun` set.
- CONVERT with counter = 0: clear `busy`, load shift register with the current sample, set bit count to DATA_WIDTH, enter SHIFT, increment `conv_count`, advance the generator.
- SHIFT + `sck` rise: shift left by one, decrement bit count; at count 0 enter IDLE.
- `sck` rises outside SHIFT are ignored.
- `sdo` = shift register MSB in SHIFT, 0 otherwise (including CONVERT).
- Generators:
  - Ramp register resets to 0 and adds RAMP_STEP mod 2^DATA_WIDTH per completed conversion.
  - LFSR is 32-bit Fibonacci, polynomial x^32+x^22+x^2+x+1, seed 1, stepped once per completed conversion; sample = LFSR[DATA_WIDTH-1:0].
  - Ramp and LFSR both advance every conversion regardless of `mode`. The sample is selected by the `mode` value present at conversion end.
- Reset: `busy`=0, `sdo`=0, `overrun`=0, `conv_count`=0, ramp=0, LFSR=1, state IDLE, `cnv_q`=`sck_q`=0. Reset mid-conversion or mid-readout discards everything with no `conv_count` increment.

## Timing
- `cnv` rise sampled at edge N → `busy`=1 after edge N, `busy`=0 after edge N+CNV_CYCLES; `busy` is high for exactly CNV_CYCLES cycles.
- The first sample MSB is valid on `sdo` from edge N+CNV_CYCLES, i.e. in the same cycle `busy` falls.
- `sck` rise sampled at edge M → next bit is on `sdo` after edge M. The reader samples `sdo` on or before its own `sck` rising edge.
- `sck` high ≥1 `clk` and low ≥1 `clk`; minimum readout is 2·DATA_WIDTH cycles.
- `cnv` held high continuously counts as a single rise; a new conversion requires `cnv` to go low for ≥1 cycle.
- `conv_count` and `overrun` update one cycle after the triggering event.

## Test plan
- Reset, `mode`=0, `cnv` pulse 1 cycle → `busy` high exactly 28 cycles; 24 `sck` pulses read 0x000000; second conversion reads 0x000001; `conv_count`=2.
- `mode`=1, `pattern`=0xA5C3F0, one conversion + 24 `sck` pulses → bits read 0xA5C3F0 MSB first; 25th `sck` pulse → `sdo`=0, state IDLE.
- `cnv` re-pulsed 10 cycles into CONVERT → `busy` still falls 28 cycles after the first rise; `overrun`=1 until an `overrun_clr` pulse, then 0.
- `mode`=2, three conversions → samples 0x000001, then the LFSR[23:0] values after one and two steps from seed 1; the bench model compares each value.
- `cnv` rise after 8 of 24 bits shifted → `sdo`=0 during `busy`; the new sample is read in full (ramp +1); no `overrun`.
- `reset` asserted at cycle 15 of CONVERT → `busy`=0 next cycle, `conv_count`=0; the next conversion reads ramp value 0.
